// File: rtl/tile_judge.sv
`default_nettype none
// ============================================================================
// Module      : tile_judge
// Description : Judges player key presses against the bottom tile row as it
//               reaches the judge line. Detects key rising edges, classifies
//               each row as hit / wrong key / missed, keeps a saturating
//               score and a lives counter, and raises a sticky game-over flag.
// Revision    : 1.0 - initial release
// ============================================================================
module tile_judge #(
  parameter int SCORE_W        = 8,    // score width, saturates at all-ones
  parameter int LIVES          = 3,    // lives loaded at reset (1..7)
  parameter bit PENALIZE_EMPTY = 1'b1  // press with no pending tile costs a life
) (
  input  logic               clk,
  input  logic               resetn,
  input  logic               shift,
  input  logic [2:0]         bottom_lane,
  input  logic [3:0]         key,
  output logic [SCORE_W-1:0] score,
  output logic [2:0]         lives,
  output logic               hit,
  output logic               miss,
  output logic               armed,
  output logic               game_over
);

  // --------------------------------------------------------------------------
  // Judge state encoding
  //   IDLE  : nothing pending since reset
  //   LOAD  : bottom row is being sampled (shifter updated on the last edge)
  //   ARMED : a tile is waiting for its key
  //   DONE  : current row has already been judged
  //   OVER  : game ended, everything frozen until reset
  // --------------------------------------------------------------------------
  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    LOAD  = 3'd1,
    ARMED = 3'd2,
    DONE  = 3'd3,
    OVER  = 3'd4
  } state_t;

  localparam logic [SCORE_W-1:0] C_SCORE_MAX = {SCORE_W{1'b1}};
  localparam logic [2:0]         C_LIVES_RST = 3'(LIVES);

  // Registered state
  state_t             r_state;
  logic [3:0]         r_key_q;
  logic [1:0]         r_lane;
  logic [SCORE_W-1:0] r_score;
  logic [2:0]         r_lives;
  logic               r_hit;
  logic               r_miss;
  logic               r_game_over;

  // Next-state values
  state_t             w_state_nxt;
  logic [1:0]         w_lane_nxt;
  logic [SCORE_W-1:0] w_score_nxt;
  logic [2:0]         w_lives_nxt;
  logic               w_hit_nxt;
  logic               w_miss_nxt;
  logic               w_game_over_nxt;

  // Judgement helpers
  logic [3:0]         w_rise;
  logic [3:0]         w_lane_mask;
  logic               w_any_rise;
  logic               w_wrong_rise;
  logic               w_right_rise;
  logic               w_code_valid;
  logic [1:0]         w_code_lane;
  logic               w_lose;
  logic               w_gain;

  // Key rising edges relative to the previous cycle's key levels
  assign w_rise       = key & ~r_key_q;
  assign w_any_rise   = |w_rise;

  // One-hot mask of the lane that the pending tile expects
  assign w_lane_mask  = 4'b0001 << r_lane;
  assign w_wrong_rise = |(w_rise & ~w_lane_mask);
  assign w_right_rise = |(w_rise & w_lane_mask);

  // Decode the bottom-row tile code: 1..4 name a lane, anything else is empty
  always_comb begin
    w_code_valid = 1'b1;
    w_code_lane  = 2'd0;
    case (bottom_lane)
      3'd1:    w_code_lane = 2'd0;
      3'd2:    w_code_lane = 2'd1;
      3'd3:    w_code_lane = 2'd2;
      3'd4:    w_code_lane = 2'd3;
      default: w_code_valid = 1'b0;
    endcase
  end

  // Next-state, judgement and score/lives update logic
  always_comb begin
    w_state_nxt     = r_state;
    w_lane_nxt      = r_lane;
    w_score_nxt     = r_score;
    w_lives_nxt     = r_lives;
    w_hit_nxt       = 1'b0;
    w_miss_nxt      = 1'b0;
    w_game_over_nxt = r_game_over;
    w_lose          = 1'b0;
    w_gain          = 1'b0;

    case (r_state)
      IDLE, DONE: begin
        if (shift) begin
          w_state_nxt = LOAD;
        end
        // A stray press with no pending tile may cost a life
        if (PENALIZE_EMPTY && w_any_rise) begin
          w_lose = 1'b1;
        end
      end

      LOAD: begin
        // Rises are ignored here; a fresh shift discards this sample
        if (shift) begin
          w_state_nxt = LOAD;
        end else if (w_code_valid) begin
          w_state_nxt = ARMED;
          w_lane_nxt  = w_code_lane;
        end else begin
          w_state_nxt = DONE;
        end
      end

      ARMED: begin
        // Wrong key beats right key; the key verdict beats a missed tile
        if (w_wrong_rise) begin
          w_lose      = 1'b1;
          w_state_nxt = shift ? LOAD : DONE;
        end else if (w_right_rise) begin
          w_gain      = 1'b1;
          w_state_nxt = shift ? LOAD : DONE;
        end else if (shift) begin
          w_lose      = 1'b1;
          w_state_nxt = LOAD;
        end
      end

      OVER: begin
        w_state_nxt = OVER;
      end

      default: begin
        w_state_nxt = IDLE;
      end
    endcase

    // Correct press: bump the score without wrapping
    if (w_gain) begin
      w_hit_nxt = 1'b1;
      if (r_score != C_SCORE_MAX) begin
        w_score_nxt = r_score + 1'b1;
      end
    end

    // Life loss: at most one per cycle, last life ends the game
    if (w_lose) begin
      w_miss_nxt  = 1'b1;
      w_lives_nxt = r_lives - 3'd1;
      if (r_lives <= 3'd1) begin
        w_lives_nxt     = 3'd0;
        w_state_nxt     = OVER;
        w_game_over_nxt = 1'b1;
      end
    end
  end

  // Key history register: tracks key levels every cycle, including reset,
  // so a key held through reset release is not seen as a press
  always_ff @(posedge clk) begin
    r_key_q <= key;
  end

  // Judge state, lane latch, score, lives and output pulse registers
  always_ff @(posedge clk) begin
    if (!resetn) begin
      r_state     <= IDLE;
      r_lane      <= 2'd0;
      r_score     <= '0;
      r_lives     <= C_LIVES_RST;
      r_hit       <= 1'b0;
      r_miss      <= 1'b0;
      r_game_over <= 1'b0;
    end else begin
      r_state     <= w_state_nxt;
      r_lane      <= w_lane_nxt;
      r_score     <= w_score_nxt;
      r_lives     <= w_lives_nxt;
      r_hit       <= w_hit_nxt;
      r_miss      <= w_miss_nxt;
      r_game_over <= w_game_over_nxt;
    end
  end

  assign score     = r_score;
  assign lives     = r_lives;
  assign hit       = r_hit;
  assign miss      = r_miss;
  assign armed     = (r_state == ARMED);
  assign game_over = r_game_over;

endmodule
`default_nettype wire

// File: tb/tb_tile_judge.sv
`default_nettype none
// ============================================================================
// Module      : tb_tile_judge
// Description : Self-checking bench for tile_judge. Two instances (default
//               score width and a 2-bit score) share stimulus; an event-level
//               model of the game rules predicts every output.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_tile_judge;

  localparam int  LIVES_P = 3;
  localparam bit  PEN_P   = 1'b1;

  logic       clk;
  logic       resetn;
  logic       shift;
  logic [2:0] bottom_lane;
  logic [3:0] key;

  logic [7:0] score;
  logic [2:0] lives;
  logic       hit, miss, armed, game_over;
  logic [1:0] score2;
  logic [2:0] lives2;
  logic       hit2, miss2, armed2, game_over2;

  int checks = 0;
  int errors = 0;

  tile_judge #(.SCORE_W(8), .LIVES(LIVES_P), .PENALIZE_EMPTY(PEN_P)) u_dut (
    .clk(clk), .resetn(resetn), .shift(shift), .bottom_lane(bottom_lane),
    .key(key), .score(score), .lives(lives), .hit(hit), .miss(miss),
    .armed(armed), .game_over(game_over)
  );

  tile_judge #(.SCORE_W(2), .LIVES(LIVES_P), .PENALIZE_EMPTY(PEN_P)) u_dut_s2 (
    .clk(clk), .resetn(resetn), .shift(shift), .bottom_lane(bottom_lane),
    .key(key), .score(score2), .lives(lives2), .hit(hit2), .miss(miss2),
    .armed(armed2), .game_over(game_over2)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- reference model (game-rule level) ----------------
  // m_tile: lane number 1..4 of the tile awaiting a press, 0 if none
  // m_sampling: the row just shifted in has not been looked at yet
  int         m_tile;
  bit         m_sampling;
  bit         m_over;
  logic [7:0] m_score8;
  logic [1:0] m_score2;
  logic [2:0] m_lives;
  bit         m_hit, m_miss;
  logic [3:0] m_prev_key;

  logic [23:0] got_vec;
  assign got_vec = {score, lives, hit, miss, armed, game_over,
                    score2, lives2, hit2, miss2, armed2, game_over2};

  function automatic logic [23:0] exp_vec();
    logic a;
    a = (m_tile != 0) && !m_sampling && !m_over;
    return {m_score8, m_lives, m_hit, m_miss, a, m_over,
            m_score2, m_lives, m_hit, m_miss, a, m_over};
  endfunction

  // Apply one cycle of inputs, advance the model, sample 1 ns after the edge
  task automatic drive(input bit rst_n, input bit sh, input logic [2:0] bl,
                       input logic [3:0] k);
    logic [3:0] rise, lane_bit;
    bit loss, gain;
    resetn = rst_n; shift = sh; bottom_lane = bl; key = k;
    if (!rst_n) begin
      m_tile = 0; m_sampling = 0; m_over = 0;
      m_score8 = 0; m_score2 = 0; m_lives = 3'(LIVES_P);
      m_hit = 0; m_miss = 0;
    end else begin
      rise = k & ~m_prev_key;
      loss = 0; gain = 0; m_hit = 0; m_miss = 0;
      if (!m_over) begin
        if (m_sampling) begin
          if (!sh) begin
            m_sampling = 0;
            m_tile = (bl >= 1 && bl <= 4) ? int'(bl) : 0;
          end
        end else if (m_tile != 0) begin
          lane_bit = 4'b0001 << (m_tile - 1);
          if ((rise & ~lane_bit) != 0) loss = 1;
          else if (rise != 0)          gain = 1;
          else if (sh)                 loss = 1;
          if (rise != 0 || sh) m_tile = 0;
          if (sh) m_sampling = 1;
        end else begin
          if (rise != 0 && PEN_P) loss = 1;
          if (sh) m_sampling = 1;
        end
        if (gain) begin
          m_hit = 1;
          if (m_score8 != 8'hFF) m_score8 = m_score8 + 1;
          if (m_score2 != 2'd3)  m_score2 = m_score2 + 1;
        end
        if (loss) begin
          m_miss = 1;
          m_lives = m_lives - 1;
          if (m_lives == 0) begin
            m_over = 1; m_tile = 0; m_sampling = 0;
          end
        end
      end
    end
    m_prev_key = k;
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    drive(0, 0, 0, 4'b0000);
    drive(0, 0, 0, 4'b0000);
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    drive(0, 0, 0, 4'b0010);
    drive(0, 0, 0, 4'b0010);
    checks++;
    if (score !== 8'd0 || lives !== 3'd3 || game_over !== 1'b0 || armed !== 1'b0
        || hit !== 1'b0 || miss !== 1'b0) begin
      errors++;
      $display("FAIL reset_values: got score=%0d lives=%0d go=%b armed=%b hit=%b miss=%b",
               score, lives, game_over, armed, hit, miss);
    end
    for (int i = 0; i < 3; i++) begin
      drive(1, 0, 0, 4'b0010);
      checks++;
      if (miss !== 1'b0 || lives !== 3'd3 || got_vec !== exp_vec()) begin
        errors++;
        $display("FAIL reset_held_key: got miss=%b lives=%0d vec=%h want miss=0 lives=3 vec=%h",
                 miss, lives, got_vec, exp_vec());
      end
    end
  endtask

  task automatic test_hit();
    do_reset();
    drive(1, 1, 0, 4'b0000);
    drive(1, 0, 3, 4'b0000);
    checks++;
    if (armed !== 1'b1) begin
      errors++; $display("FAIL hit_armed: got armed=%b want 1", armed);
    end
    for (int i = 0; i < 3; i++) drive(1, 0, 0, 4'b0000);
    drive(1, 0, 0, 4'b0100);
    checks++;
    if (hit !== 1'b1 || miss !== 1'b0 || score !== 8'd1 || armed !== 1'b0) begin
      errors++;
      $display("FAIL hit_pulse: got hit=%b miss=%b score=%0d armed=%b want 1 0 1 0",
               hit, miss, score, armed);
    end
    drive(1, 0, 0, 4'b0000);
    drive(1, 0, 0, 4'b0100);
    checks++;
    if (miss !== 1'b1 || hit !== 1'b0 || lives !== 3'd2 || score !== 8'd1) begin
      errors++;
      $display("FAIL hit_done_press: got miss=%b hit=%b lives=%0d score=%0d want 1 0 2 1",
               miss, hit, lives, score);
    end
  endtask

  task automatic test_wrong_key();
    do_reset();
    drive(1, 1, 0, 4'b0000);
    drive(1, 0, 2, 4'b0000);
    drive(1, 0, 0, 4'b0011);
    checks++;
    if (miss !== 1'b1 || hit !== 1'b0 || lives !== 3'd2 || score !== 8'd0 || armed !== 1'b0) begin
      errors++;
      $display("FAIL wrong_key: got miss=%b hit=%b lives=%0d score=%0d armed=%b want 1 0 2 0 0",
               miss, hit, lives, score, armed);
    end
    drive(1, 0, 0, 4'b0011);
    checks++;
    if (got_vec !== exp_vec() || lives !== 3'd2 || miss !== 1'b0) begin
      errors++;
      $display("FAIL wrong_key_after: got vec=%h want %h", got_vec, exp_vec());
    end
  endtask

  task automatic test_missed_tile();
    do_reset();
    drive(1, 1, 0, 4'b0000);
    drive(1, 0, 4, 4'b0000);
    drive(1, 0, 0, 4'b0000);
    drive(1, 0, 0, 4'b0000);
    drive(1, 1, 0, 4'b0000);
    checks++;
    if (miss !== 1'b1 || lives !== 3'd2 || armed !== 1'b0) begin
      errors++;
      $display("FAIL missed_tile: got miss=%b lives=%0d armed=%b want 1 2 0", miss, lives, armed);
    end
    drive(1, 0, 1, 4'b0000);
    checks++;
    if (armed !== 1'b1 || miss !== 1'b0) begin
      errors++;
      $display("FAIL missed_resample: got armed=%b miss=%b want 1 0", armed, miss);
    end
  endtask

  task automatic test_hit_with_shift();
    do_reset();
    drive(1, 1, 0, 4'b0000);
    drive(1, 0, 1, 4'b0000);
    drive(1, 1, 0, 4'b0001);
    checks++;
    if (hit !== 1'b1 || miss !== 1'b0 || score !== 8'd1 || lives !== 3'd3) begin
      errors++;
      $display("FAIL hit_shift: got hit=%b miss=%b score=%0d lives=%0d want 1 0 1 3",
               hit, miss, score, lives);
    end
    drive(1, 0, 2, 4'b0001);
    checks++;
    if (armed !== 1'b1 || got_vec !== exp_vec()) begin
      errors++;
      $display("FAIL hit_shift_load: got armed=%b vec=%h want armed=1 vec=%h",
               armed, got_vec, exp_vec());
    end
  endtask

  task automatic test_game_over();
    do_reset();
    drive(1, 1, 0, 4'b0000);
    drive(1, 0, 1, 4'b0000);
    for (int i = 0; i < 3; i++) begin
      drive(1, 1, 0, 4'b0000);
      checks++;
      if (miss !== 1'b1 || lives !== 3'(2 - i) || game_over !== (i == 2)) begin
        errors++;
        $display("FAIL over_miss%0d: got miss=%b lives=%0d go=%b want 1 %0d %0d",
                 i, miss, lives, game_over, 2 - i, (i == 2));
      end
      drive(1, 0, 1, 4'b0000);
    end
    for (int i = 0; i < 12; i++) begin
      drive(1, 1'($urandom_range(0, 1)), 3'($urandom_range(0, 7)), 4'($urandom));
      checks++;
      if (lives !== 3'd0 || score !== 8'd0 || hit !== 1'b0 || miss !== 1'b0
          || armed !== 1'b0 || game_over !== 1'b1) begin
        errors++;
        $display("FAIL over_frozen: got lives=%0d score=%0d hit=%b miss=%b armed=%b go=%b",
                 lives, score, hit, miss, armed, game_over);
      end
    end
    drive(0, 0, 0, 4'b0000);
    checks++;
    if (lives !== 3'd3 || game_over !== 1'b0) begin
      errors++;
      $display("FAIL over_reset: got lives=%0d go=%b want 3 0", lives, game_over);
    end
  endtask

  task automatic test_saturate();
    do_reset();
    for (int i = 0; i < 4; i++) begin
      drive(1, 1, 0, 4'b0000);
      drive(1, 0, 1, 4'b0000);
      drive(1, 0, 0, 4'b0001);
      drive(1, 0, 0, 4'b0000);
    end
    checks++;
    if (score2 !== 2'd3 || score !== 8'd4 || lives !== 3'd3) begin
      errors++;
      $display("FAIL saturate: got score2=%0d score=%0d lives=%0d want 3 4 3",
               score2, score, lives);
    end
  endtask

  task automatic test_random();
    logic [3:0] k;
    bit rn;
    k = 4'b0000;
    do_reset();
    for (int i = 0; i < 4000; i++) begin
      rn = ($urandom_range(0, 149) != 0);
      if ($urandom_range(0, 3) == 0) k = 4'($urandom);
      drive(rn, ($urandom_range(0, 3) == 0), 3'($urandom_range(0, 7)), k);
      checks++;
      if (got_vec !== exp_vec()) begin
        errors++;
        $display("FAIL random_cycle%0d: got vec=%h want %h", i, got_vec, exp_vec());
      end
    end
  endtask

  initial begin
    resetn = 1'b0; shift = 1'b0; bottom_lane = 3'd0; key = 4'd0;
    m_prev_key = 4'd0; m_tile = 0; m_sampling = 0; m_over = 0;
    m_score8 = 0; m_score2 = 0; m_lives = 3'(LIVES_P); m_hit = 0; m_miss = 0;
    test_reset();
    test_hit();
    test_wrong_key();
    test_missed_tile();
    test_hit_with_shift();
    test_game_over();
    test_saturate();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
